// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared state, opcode and mux-select encodings for the multicycle MIPS controller
package mips_mc_pkg;

    localparam int ST_BITS = 5;

    typedef enum logic [ST_BITS-1:0] {
        S_FETCH     = 5'd0,
        S_FWAIT     = 5'd1,
        S_IR_LOAD   = 5'd2,
        S_DECODE    = 5'd3,
        S_R_EXEC    = 5'd4,
        S_R_WB      = 5'd5,
        S_MEM_ADDR  = 5'd6,
        S_MEM_RD    = 5'd7,
        S_MWAIT     = 5'd8,
        S_MDR_LOAD  = 5'd9,
        S_LW_WB     = 5'd10,
        S_SW_WR     = 5'd11,
        S_BRANCH    = 5'd12,
        S_JUMP      = 5'd13,
        S_ADDI_EXEC = 5'd14,
        S_ADDI_WB   = 5'd15,
        S_ILLEGAL   = 5'd16
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] FB_B     = 2'b00;
    localparam logic [1:0] FB_FOUR  = 2'b01;
    localparam logic [1:0] FB_IMM   = 2'b10;
    localparam logic [1:0] FB_IMMSH = 2'b11;

    function automatic state_e decode_op(input logic [5:0] op);
        return op == OP_R                 ? S_R_EXEC    :
               op == OP_LW || op == OP_SW ? S_MEM_ADDR  :
               op == OP_BEQ               ? S_BRANCH    :
               op == OP_J                 ? S_JUMP      :
               op == OP_ADDI              ? S_ADDI_EXEC : S_ILLEGAL;
    endfunction

endpackage

// File: rtl/mips_mc_control_wait.sv
// mem_wait_counter: saturating down-counter timing the memory wait states
module mem_wait_counter #(
    parameter int WAIT = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic load,
    output logic done
);
    localparam int CW = WAIT > 0 ? $clog2(WAIT + 1) : 1;
    localparam logic [CW-1:0] LOAD_V = CW'(WAIT > 0 ? WAIT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d = load ? LOAD_V : cnt_q - CW'(cnt_q != '0);
    assign done  = cnt_q == '0;

    always_ff @(posedge Clock) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: Moore control FSM for the multicycle MIPS datapath with configurable memory wait states
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 5
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCEsc,
    output logic               PCEscCond,
    output logic [1:0]         PCFonte,
    output logic               CtrMem,
    output logic               IouD,
    output logic               IREsc,
    output logic               MDRCtrl,
    output logic               RegACtrl,
    output logic               RegBCtrl,
    output logic               ULASaidaCtrl,
    output logic               ULAFonteA,
    output logic [1:0]         ULAFonteB,
    output logic [1:0]         ULAOp,
    output logic               RegDst,
    output logic               MemParaReg,
    output logic               RegWrite,
    output logic               Excecao,
    output logic [STATE_W-1:0] state
);
    state_e state_q, state_d;
    logic   wait_load, wait_done;
    logic   unused_in;

    // Funct reaches the ALU decoder directly and Zero gates the PC write outside this block
    assign unused_in = ^{Funct, Zero};

    // FETCH and MEM_RD are the sole predecessors of the two wait states
    assign wait_load = state_q == S_FETCH || state_q == S_MEM_RD;
    assign state     = STATE_W'(state_q);

    mem_wait_counter #(.WAIT(MEM_WAIT)) u_wait (
        .Clock(Clock),
        .Reset(Reset),
        .load (wait_load),
        .done (wait_done)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = S_FETCH;
        PCEsc        = 1'b0;
        PCEscCond    = 1'b0;
        PCFonte      = PC_ALU;
        CtrMem       = 1'b0;
        IouD         = 1'b0;
        IREsc        = 1'b0;
        MDRCtrl      = 1'b0;
        RegACtrl     = 1'b0;
        RegBCtrl     = 1'b0;
        ULASaidaCtrl = 1'b0;
        ULAFonteA    = 1'b0;
        ULAFonteB    = FB_B;
        ULAOp        = ALU_ADD;
        RegDst       = 1'b0;
        MemParaReg   = 1'b0;
        RegWrite     = 1'b0;
        Excecao      = 1'b0;
        case (state_q)
            S_FETCH:   state_d = MEM_WAIT == 0 ? S_IR_LOAD : S_FWAIT;
            S_FWAIT:   state_d = wait_done ? S_IR_LOAD : S_FWAIT;
            S_IR_LOAD: begin
                IREsc     = 1'b1;
                PCEsc     = 1'b1;
                ULAFonteB = FB_FOUR;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                RegACtrl     = 1'b1;
                RegBCtrl     = 1'b1;
                ULASaidaCtrl = 1'b1;
                ULAFonteB    = FB_IMMSH;
                state_d      = decode_op(OpCode);
            end
            S_R_EXEC: begin
                ULAFonteA    = 1'b1;
                ULAOp        = ALU_FUNCT;
                ULASaidaCtrl = 1'b1;
                state_d      = S_R_WB;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ULAFonteA    = 1'b1;
                ULAFonteB    = FB_IMM;
                ULASaidaCtrl = 1'b1;
                state_d      = state_q == S_ADDI_EXEC ? S_ADDI_WB :
                               OpCode == OP_LW        ? S_MEM_RD  : S_SW_WR;
            end
            S_MEM_RD: begin
                IouD    = 1'b1;
                state_d = MEM_WAIT == 0 ? S_MDR_LOAD : S_MWAIT;
            end
            S_MWAIT: begin
                IouD    = 1'b1;
                state_d = wait_done ? S_MDR_LOAD : S_MWAIT;
            end
            S_MDR_LOAD: begin
                IouD    = 1'b1;
                MDRCtrl = 1'b1;
                state_d = S_LW_WB;
            end
            S_LW_WB: begin
                MemParaReg = 1'b1;
                RegWrite   = 1'b1;
            end
            S_SW_WR: begin
                IouD   = 1'b1;
                CtrMem = 1'b1;
            end
            S_BRANCH: begin
                ULAFonteA = 1'b1;
                ULAOp     = ALU_SUB;
                PCEscCond = 1'b1;
                PCFonte   = PC_ALUOUT;
            end
            S_JUMP: begin
                PCEsc   = 1'b1;
                PCFonte = PC_JUMP;
            end
            S_ADDI_WB: RegWrite = 1'b1;
            S_ILLEGAL: Excecao  = 1'b1;
            default:   state_d  = S_FETCH;
        endcase
    end
endmodule
